// File: rtl/tick_phase_sequencer_if.sv
// Configuration port of the tick/phase sequencer: per-phase duration writes
// over a valid/ready handshake. The host side is the master.
interface tick_phase_sequencer_if #(
    parameter int NPHASE = 4,
    parameter int DUR_W  = 8
);
    localparam int PH_W = $clog2(NPHASE);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [PH_W-1:0]  cfg_phase;
    logic [DUR_W-1:0] cfg_dur;

    modport master (
        output cfg_valid,
        output cfg_phase,
        output cfg_dur,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_phase,
        input  cfg_dur,
        output cfg_ready
    );
endinterface

// File: rtl/tick_phase_sequencer.sv
// Tick/phase sequencer: divides clk10 down to a one-cycle tick and walks a
// cyclic schedule of NPHASE phases, each lasting a programmable tick count.
// The phase output shows the phase the current tick belongs to, so it moves
// on in the cycle after the tick that completes a phase.
module tick_phase_sequencer #(
    parameter int DIV_DEFAULT = 10000000,
    parameter int DIV_W       = 26,
    parameter int NPHASE      = 4,
    parameter int DUR_W       = 8,
    localparam int PH_W       = $clog2(NPHASE)
) (
    input  logic                  clk10,
    input  logic                  reset,
    input  logic [DIV_W-1:0]      div_value_in,
    tick_phase_sequencer_if.slave cfg,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  stop,
    output logic                  tick,
    output logic [PH_W-1:0]       phase,
    output logic                  phase_done,
    output logic                  busy
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DIV_DEF_C = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] CNT_ZERO  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] CNT_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DUR_W-1:0] DUR_ZERO  = {DUR_W{1'b0}};
    localparam logic [DUR_W-1:0] DUR_ONE   = {{(DUR_W-1){1'b0}}, 1'b1};
    localparam logic [PH_W-1:0]  PH_ZERO   = {PH_W{1'b0}};
    localparam logic [PH_W-1:0]  PH_ONE    = {{(PH_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_s;
    logic [DIV_W-1:0] cnt_r, cnt_s, cnt_eff_s;
    logic [DIV_W-1:0] div_r, div_s, div_eff_s;
    logic [DUR_W-1:0] rem_r, rem_s, rem_eff_s;
    logic [PH_W-1:0]  ph_r, ph_s, ph_eff_s, ph_nxt_s;
    logic [PH_W-1:0]  phase_r, phase_s;
    logic             tick_r, tick_s;
    logic             done_r, done_s;
    logic             step_s;
    logic             wr_s;
    logic [DUR_W-1:0] dur_in_s;
    logic [DUR_W-1:0] dur_r      [NPHASE];
    logic [DUR_W-1:0] dur_view_s [NPHASE];

    assign wr_s          = cfg.cfg_valid && (state_r == ST_IDLE);
    assign cfg.cfg_ready = (state_r == ST_IDLE);
    assign busy          = (state_r != ST_IDLE);
    assign tick          = tick_r;
    assign phase_done    = done_r;
    assign phase         = phase_r;

    // Incoming duration with zero promoted to one tick
    always_comb begin
        if (cfg.cfg_dur == DUR_ZERO) begin
            dur_in_s = DUR_ONE;
        end else begin
            dur_in_s = cfg.cfg_dur;
        end
    end

    // Table view with this cycle's write forwarded, so a start in the same cycle sees it
    always_comb begin
        for (int i = 0; i < NPHASE; i++) begin
            if (wr_s && (cfg.cfg_phase == PH_W'(i))) begin
                dur_view_s[i] = dur_in_s;
            end else begin
                dur_view_s[i] = dur_r[i];
            end
        end
    end

    // Next state, divider and schedule update; priority stop > pause > start
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        rem_s     = rem_r;
        ph_s      = ph_r;
        div_s     = div_r;
        tick_s    = 1'b0;
        done_s    = 1'b0;
        step_s    = 1'b0;
        cnt_eff_s = cnt_r;
        rem_eff_s = rem_r;
        ph_eff_s  = ph_r;
        div_eff_s = div_r;
        case (state_r)
            ST_IDLE: begin
                if (stop) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                    rem_s   = DUR_ZERO;
                    ph_s    = PH_ZERO;
                end else if (start) begin
                    if (div_value_in == CNT_ZERO) begin
                        div_eff_s = DIV_DEF_C;
                    end else begin
                        div_eff_s = div_value_in;
                    end
                    // The start edge itself is the first counted cycle
                    cnt_eff_s = CNT_ZERO;
                    rem_eff_s = dur_view_s[0];
                    ph_eff_s  = PH_ZERO;
                    div_s     = div_eff_s;
                    cnt_s     = CNT_ZERO;
                    rem_s     = rem_eff_s;
                    ph_s      = PH_ZERO;
                    if (pause) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_RUN;
                        step_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN, ST_HOLD: begin
                if (stop) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                    rem_s   = DUR_ZERO;
                    ph_s    = PH_ZERO;
                end else if (pause) begin
                    state_s = ST_HOLD;
                end else begin
                    // The HOLD->RUN edge counts, so no cycle is lost on resume
                    state_s = ST_RUN;
                    step_s  = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                rem_s   = DUR_ZERO;
                ph_s    = PH_ZERO;
            end
        endcase

        ph_nxt_s = ph_eff_s + PH_ONE;
        if (step_s) begin
            if (cnt_eff_s == (div_eff_s - CNT_ONE)) begin
                cnt_s  = CNT_ZERO;
                tick_s = 1'b1;
                if (rem_eff_s == DUR_ONE) begin
                    done_s = 1'b1;
                    ph_s   = ph_nxt_s;
                    rem_s  = dur_view_s[ph_nxt_s];
                end else begin
                    rem_s  = rem_eff_s - DUR_ONE;
                end
            end else begin
                cnt_s = cnt_eff_s + CNT_ONE;
            end
        end else begin
            tick_s = 1'b0;
        end

        if (state_s == ST_IDLE) begin
            phase_s = PH_ZERO;
        end else begin
            phase_s = ph_r;
        end
    end

    // Control state, divider, schedule position and registered outputs
    always_ff @(posedge clk10 or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            rem_r   <= DUR_ZERO;
            ph_r    <= PH_ZERO;
            div_r   <= DIV_DEF_C;
            tick_r  <= 1'b0;
            done_r  <= 1'b0;
            phase_r <= PH_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            rem_r   <= rem_s;
            ph_r    <= ph_s;
            div_r   <= div_s;
            tick_r  <= tick_s;
            done_r  <= done_s;
            phase_r <= phase_s;
        end
    end

    // Duration table: all ones after reset, written only while idle
    always_ff @(posedge clk10 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPHASE; i++) begin
                dur_r[i] <= DUR_ONE;
            end
        end else if (wr_s) begin
            dur_r[cfg.cfg_phase] <= dur_in_s;
        end else begin
            dur_r <= dur_r;
        end
    end
endmodule

// File: tb/tb_tick_phase_sequencer.sv
// Directed bench for tick_phase_sequencer: tables of {cycles to next tick,
// expected tick/phase_done/phase} plus hand-written multi-cycle sequences.
module tb_tick_phase_sequencer;
    logic        clk10 = 1'b0;
    logic        reset;
    logic [25:0] div_value_in;
    logic        start, pause, stop;
    logic        tick, phase_done, busy;
    logic [1:0]  phase;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int         n;
        logic       t;
        logic       d;
        logic [1:0] ph;
    } row_t;

    row_t rows[$];

    tick_phase_sequencer_if #(.NPHASE(4), .DUR_W(8)) cfg_if ();

    tick_phase_sequencer #(
        .DIV_DEFAULT(10),
        .DIV_W(26),
        .NPHASE(4),
        .DUR_W(8)
    ) dut (
        .clk10(clk10),
        .reset(reset),
        .div_value_in(div_value_in),
        .cfg(cfg_if),
        .start(start),
        .pause(pause),
        .stop(stop),
        .tick(tick),
        .phase(phase),
        .phase_done(phase_done),
        .busy(busy)
    );

    always #5 clk10 = ~clk10;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk10);
        #1;
    endtask

    task automatic add(input int n, input logic t, input logic d, input logic [1:0] ph);
        row_t r;
        r.n = n; r.t = t; r.d = d; r.ph = ph;
        rows.push_back(r);
    endtask

    // Each row: n cycles later a tick is expected; no tick/phase_done before it
    task automatic apply_rows(input string tag);
        foreach (rows[r]) begin
            int quiet = 0;
            for (int c = 0; c < rows[r].n; c++) begin
                step();
                if ((c < rows[r].n - 1) && (tick || phase_done)) quiet++;
            end
            if (rows[r].n > 1) chk($sformatf("%s row%0d quiet", tag, r), quiet, 0);
            chk($sformatf("%s row%0d tick", tag, r), int'(tick), int'(rows[r].t));
            chk($sformatf("%s row%0d phase_done", tag, r), int'(phase_done), int'(rows[r].d));
            chk($sformatf("%s row%0d phase", tag, r), int'(phase), int'(rows[r].ph));
        end
        rows.delete();
    endtask

    task automatic do_start(input string tag, input logic [25:0] d);
        start = 1'b1;
        div_value_in = d;
        step();
        start = 1'b0;
        chk({tag, " start busy"}, int'(busy), 1);
        chk({tag, " start ready"}, int'(cfg_if.cfg_ready), 0);
    endtask

    task automatic do_stop(input string tag);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk({tag, " stop busy"}, int'(busy), 0);
        chk({tag, " stop phase"}, int'(phase), 0);
        chk({tag, " stop tick"}, int'(tick), 0);
        chk({tag, " stop ready"}, int'(cfg_if.cfg_ready), 1);
    endtask

    task automatic cfg_write(input logic [1:0] p, input logic [7:0] d);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_phase = p;
        cfg_if.cfg_dur   = d;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        div_value_in = 26'd0;
        start = 1'b0; pause = 1'b0; stop = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_phase = 2'd0;
        cfg_if.cfg_dur   = 8'd0;
        repeat (2) step();
        chk("reset tick", int'(tick), 0);
        chk("reset phase_done", int'(phase_done), 0);
        chk("reset phase", int'(phase), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset ready", int'(cfg_if.cfg_ready), 1);
        reset = 1'b1;
        step();

        // D=4, default durations: every tick closes a phase
        do_start("d4", 26'd4);
        chk("d4 first tick", int'(tick), 0);
        add(3, 1'b1, 1'b1, 2'd0);
        add(4, 1'b1, 1'b1, 2'd1);
        add(4, 1'b1, 1'b1, 2'd2);
        add(4, 1'b1, 1'b1, 2'd3);
        add(4, 1'b1, 1'b1, 2'd0);
        apply_rows("d4");
        do_stop("d4");

        // Durations {2,1,3,1}; a write attempt while running must be ignored
        cfg_write(2'd0, 8'd2);
        cfg_write(2'd1, 8'd1);
        cfg_write(2'd2, 8'd3);
        cfg_write(2'd3, 8'd1);
        do_start("sched", 26'd4);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_phase = 2'd0;
        cfg_if.cfg_dur   = 8'd5;
        step();
        chk("sched busy write ready", int'(cfg_if.cfg_ready), 0);
        cfg_if.cfg_valid = 1'b0;
        add(2, 1'b1, 1'b0, 2'd0);
        add(4, 1'b1, 1'b1, 2'd0);
        add(4, 1'b1, 1'b1, 2'd1);
        add(4, 1'b1, 1'b0, 2'd2);
        add(4, 1'b1, 1'b0, 2'd2);
        add(4, 1'b1, 1'b1, 2'd2);
        add(4, 1'b1, 1'b1, 2'd3);
        add(4, 1'b1, 1'b0, 2'd0);
        add(4, 1'b1, 1'b1, 2'd0);
        add(4, 1'b1, 1'b1, 2'd1);
        add(4, 1'b1, 1'b0, 2'd2);
        apply_rows("sched");
        step();
        step();
        do_stop("sched");

        // Restart after stop keeps the programmed table
        do_start("retain", 26'd4);
        add(3, 1'b1, 1'b0, 2'd0);
        add(4, 1'b1, 1'b1, 2'd0);
        add(4, 1'b1, 1'b1, 2'd1);
        apply_rows("retain");
        do_stop("retain");

        // Same-cycle write of duration 0 with start: phase 0 lasts one tick
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_phase = 2'd0;
        cfg_if.cfg_dur   = 8'd0;
        do_start("dur0", 26'd4);
        cfg_if.cfg_valid = 1'b0;
        add(3, 1'b1, 1'b1, 2'd0);
        add(4, 1'b1, 1'b1, 2'd1);
        add(4, 1'b1, 1'b0, 2'd2);
        apply_rows("dur0");
        do_stop("dur0");

        // div_value_in=0 selects the default ratio; later changes have no effect
        do_start("ddef", 26'd0);
        div_value_in = 26'd3;
        add(9, 1'b1, 1'b1, 2'd0);
        add(10, 1'b1, 1'b1, 2'd1);
        apply_rows("ddef");
        do_stop("ddef");

        // D=1: tick every cycle, table {1,1,3,1}
        do_start("d1", 26'd1);
        chk("d1 s1 tick", int'(tick), 1);
        chk("d1 s1 phase_done", int'(phase_done), 1);
        chk("d1 s1 phase", int'(phase), 0);
        add(1, 1'b1, 1'b1, 2'd1);
        add(1, 1'b1, 1'b0, 2'd2);
        add(1, 1'b1, 1'b0, 2'd2);
        add(1, 1'b1, 1'b1, 2'd2);
        add(1, 1'b1, 1'b1, 2'd3);
        add(1, 1'b1, 1'b1, 2'd0);
        apply_rows("d1");
        do_stop("d1");

        // D=5, pause 7 cycles once the counter reads 2: tick moves from cycle 5 to 12
        do_start("pause", 26'd5);
        step();
        pause = 1'b1;
        begin
            int hold_ticks = 0;
            int hold_idle  = 0;
            for (int c = 0; c < 7; c++) begin
                step();
                if (tick || phase_done) hold_ticks++;
                if (!busy) hold_idle++;
            end
            chk("pause no tick in hold", hold_ticks, 0);
            chk("pause busy in hold", hold_idle, 0);
        end
        pause = 1'b0;
        add(3, 1'b1, 1'b1, 2'd0);
        add(5, 1'b1, 1'b1, 2'd1);
        apply_rows("pause");
        do_stop("pause");

        // Async reset mid-run clears state and the duration table
        do_start("areset", 26'd2);
        step();
        step();
        #2 reset = 1'b0;
        #1;
        chk("areset tick", int'(tick), 0);
        chk("areset phase", int'(phase), 0);
        chk("areset busy", int'(busy), 0);
        chk("areset ready", int'(cfg_if.cfg_ready), 1);
        #2 reset = 1'b1;
        step();
        do_start("after_reset", 26'd4);
        add(3, 1'b1, 1'b1, 2'd0);
        add(4, 1'b1, 1'b1, 2'd1);
        add(4, 1'b1, 1'b1, 2'd2);
        add(4, 1'b1, 1'b1, 2'd3);
        apply_rows("after_reset");
        do_stop("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
